// File: rtl/mips_ctrl_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, load-use stall and jump/branch flush generation.
module mips_ctrl_pipe #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               ex_taken,
  output logic               stall,
  output logic               if_flush,
  output logic               id_jump,
  output logic               id_jr,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic               ex_bne,
  output logic [REG_W-1:0]   ex_dst,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_link,
  output logic [REG_W-1:0]   wb_dst,
  output logic               illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] A_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] A_OR  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] A_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] A_SLT = ALUOP_W'(3'b111);

  localparam logic [REG_W-1:0] LINK_REG = {REG_W{1'b1}};

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               branch;
    logic               bne;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               link;
    logic [REG_W-1:0]   dst;
  } id_ex_t;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             link;
    logic [REG_W-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             link;
    logic [REG_W-1:0] dst;
  } mem_wb_t;

  id_ex_t  dec, id_ex_d, id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  logic    legal, jump, jr, use_rt, hazard, illegal_d, illegal_q;

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    jump   = 1'b0;
    jr     = 1'b0;
    use_rt = 1'b0;
    unique case (id_opcode)
      OP_R: begin
        use_rt        = 1'b1;
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.dst       = id_rd;
        unique case (id_funct)
          FN_ADD: dec.aluop = A_ADD;
          FN_SUB: dec.aluop = A_SUB;
          FN_AND: dec.aluop = A_AND;
          FN_OR:  dec.aluop = A_OR;
          FN_SLT: dec.aluop = A_SLT;
          FN_JR: begin
            dec  = '0;
            jump = 1'b1;
            jr   = 1'b1;
          end
          default: begin
            dec   = '0;
            legal = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ORI: begin
        legal         = 1'b1;
        dec.aluop     = (id_opcode == OP_ORI) ? A_OR : A_ADD;
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.dst       = id_rt;
      end
      OP_LW: begin
        legal          = 1'b1;
        dec.aluop      = A_ADD;
        dec.alusrc     = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.dst        = id_rt;
      end
      OP_SW: begin
        legal         = 1'b1;
        use_rt        = 1'b1;
        dec.aluop     = A_ADD;
        dec.alusrc    = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal      = 1'b1;
        use_rt     = 1'b1;
        dec.aluop  = A_SUB;
        dec.branch = 1'b1;
        dec.bne    = (id_opcode == OP_BNE);
      end
      OP_J: begin
        legal = 1'b1;
        jump  = 1'b1;
      end
      OP_JAL: begin
        legal         = 1'b1;
        jump          = 1'b1;
        dec.reg_write = 1'b1;
        dec.link      = 1'b1;
        dec.dst       = LINK_REG;
      end
      default: ;
    endcase
  end

  // a load in EX cannot forward to ID's consumer until it reaches MEM
  assign hazard = id_valid && id_ex.mem_read && (id_ex.dst != '0) &&
                  ((id_ex.dst == id_rs) ||
                   (use_rt && (id_ex.dst == id_rt)));

  assign stall     = hazard && !ex_taken;
  assign id_jump   = id_valid && jump && !ex_taken;
  assign id_jr     = id_valid && jr && !ex_taken;
  assign if_flush  = (id_jump && !stall) || ex_taken;
  assign illegal_d = id_valid && !legal && !stall && !ex_taken;
  assign id_ex_d   = (!id_valid || stall || ex_taken) ? '0 : dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex     <= '0;
      ex_mem    <= '0;
      mem_wb    <= '0;
      illegal_q <= 1'b0;
    end else begin
      id_ex     <= id_ex_d;
      illegal_q <= illegal_d;
      ex_mem    <= {id_ex.mem_read, id_ex.mem_write, id_ex.reg_write,
                    id_ex.mem_to_reg, id_ex.link, id_ex.dst};
      mem_wb    <= {ex_mem.reg_write, ex_mem.mem_to_reg,
                    ex_mem.link, ex_mem.dst};
    end
  end

  assign ex_aluop      = id_ex.aluop;
  assign ex_alusrc     = id_ex.alusrc;
  assign ex_branch     = id_ex.branch;
  assign ex_bne        = id_ex.bne;
  assign ex_dst        = id_ex.dst;
  assign mem_read      = ex_mem.mem_read;
  assign mem_write     = ex_mem.mem_write;
  assign wb_reg_write  = mem_wb.reg_write;
  assign wb_mem_to_reg = mem_wb.mem_to_reg;
  assign wb_link       = mem_wb.link;
  assign wb_dst        = mem_wb.dst;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Bench for mips_ctrl_pipe: decode table plus hazard, flush,
// illegal and asynchronous reset sequences, scoreboarded per stage.
module tb_mips_ctrl_pipe;

  localparam logic [5:0] R    = 6'h00;
  localparam logic [5:0] J    = 6'h02;
  localparam logic [5:0] JAL  = 6'h03;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] BNE  = 6'h05;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] ORI  = 6'h0d;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2b;
  localparam logic [5:0] ADD  = 6'h20;
  localparam logic [5:0] SUB  = 6'h22;
  localparam logic [5:0] AND_ = 6'h24;
  localparam logic [5:0] OR_  = 6'h25;
  localparam logic [5:0] SLT  = 6'h2a;
  localparam logic [5:0] JR   = 6'h08;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       bne;
    logic [4:0] dst;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic       illegal;
  } rec_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       taken;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    rec_t       e;
    logic [3:0] comb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, ex_taken;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, if_flush, id_jump, id_jr;
  logic [2:0] ex_aluop;
  logic       ex_alusrc, ex_branch, ex_bne;
  logic [4:0] ex_dst, wb_dst;
  logic       mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg, wb_link, illegal;

  int checks = 0;
  int errors = 0;
  rec_t q[$];
  vec_t tbl[$];

  mips_ctrl_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_taken(ex_taken), .stall(stall), .if_flush(if_flush),
    .id_jump(id_jump), .id_jr(id_jr), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_bne(ex_bne),
    .ex_dst(ex_dst), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_link(wb_link), .wb_dst(wb_dst), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(logic [2:0] a, logic src, logic br,
      logic bn, logic [4:0] d, logic mr, logic mw, logic rw,
      logic m2r, logic lk, logic ill);
    return '{a, src, br, bn, d, mr, mw, rw, m2r, lk, ill};
  endfunction

  function automatic in_t mi(logic v, logic [5:0] op, logic [5:0] fn,
      logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic tk);
    return '{v, op, fn, rs, rt, rd, tk};
  endfunction

  function automatic logic [31:0] all_out();
    return {6'd0, stall, if_flush, id_jump, id_jr, ex_aluop, ex_alusrc,
            ex_branch, ex_bne, ex_dst, mem_read, mem_write,
            wb_reg_write, wb_mem_to_reg, wb_link, wb_dst, illegal};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc(string n, in_t i, rec_t e, logic [3:0] comb);
    @(negedge clk);
    id_valid  = i.valid;
    id_opcode = i.op;
    id_funct  = i.fn;
    id_rs     = i.rs;
    id_rt     = i.rt;
    id_rd     = i.rd;
    ex_taken  = i.taken;
    #1;
    chk({n, " comb"}, {28'd0, stall, if_flush, id_jump, id_jr}, {28'd0, comb});
    q.push_back(e);
    @(posedge clk);
    #1;
    chk({n, " ex"},
        {18'd0, ex_aluop, ex_alusrc, ex_branch, ex_bne, ex_dst, illegal},
        {18'd0, q[3].aluop, q[3].alusrc, q[3].branch, q[3].bne,
         q[3].dst, q[3].illegal});
    chk({n, " mem"}, {30'd0, mem_read, mem_write},
        {30'd0, q[2].mem_read, q[2].mem_write});
    chk({n, " wb"},
        {24'd0, wb_reg_write, wb_mem_to_reg, wb_link, wb_dst},
        {24'd0, q[1].reg_write, q[1].mem_to_reg, q[1].link, q[1].dst});
    void'(q.pop_front());
  endtask

  task automatic drain(string n);
    for (int k = 0; k < 3; k++)
      cyc(n, mi(0, R, ADD, 0, 0, 0, 0), '0, 4'b0000);
  endtask

  initial begin
    rec_t z;
    z = '0;
    tbl.push_back('{"add",   mi(1, R, ADD, 1, 2, 3, 0),
      mk(3'b010, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"sub",   mi(1, R, SUB, 1, 2, 3, 0),
      mk(3'b110, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"and",   mi(1, R, AND_, 1, 2, 3, 0),
      mk(3'b000, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"or",    mi(1, R, OR_, 1, 2, 3, 0),
      mk(3'b001, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"slt",   mi(1, R, SLT, 1, 2, 3, 0),
      mk(3'b111, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"jr",    mi(1, R, JR, 1, 2, 3, 0), z, 4'b0111});
    tbl.push_back('{"addi",  mi(1, ADDI, 0, 1, 2, 3, 0),
      mk(3'b010, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"ori",   mi(1, ORI, 0, 1, 2, 3, 0),
      mk(3'b001, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0), 4'b0000});
    tbl.push_back('{"lw",    mi(1, LW, 0, 1, 9, 3, 0),
      mk(3'b010, 1, 0, 0, 9, 1, 0, 1, 1, 0, 0), 4'b0000});
    tbl.push_back('{"sw",    mi(1, SW, 0, 1, 2, 3, 0),
      mk(3'b010, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 4'b0000});
    tbl.push_back('{"beq",   mi(1, BEQ, 0, 1, 2, 3, 0),
      mk(3'b110, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 4'b0000});
    tbl.push_back('{"bne",   mi(1, BNE, 0, 1, 2, 3, 0),
      mk(3'b110, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 4'b0000});
    tbl.push_back('{"j",     mi(1, J, 0, 1, 2, 3, 0), z, 4'b0110});
    tbl.push_back('{"jal",   mi(1, JAL, 0, 1, 2, 3, 0),
      mk(3'b000, 0, 0, 0, 31, 0, 0, 1, 0, 1, 0), 4'b0110});
    tbl.push_back('{"illop", mi(1, 6'h3f, 0, 1, 2, 3, 0),
      mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 4'b0000});
    tbl.push_back('{"illfn", mi(1, R, 6'h3f, 1, 2, 3, 0),
      mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 4'b0000});
    tbl.push_back('{"novld", mi(0, R, ADD, 1, 2, 3, 0), z, 4'b0000});

    rst = 1'b1;
    {id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, ex_taken} = '0;
    q = '{z, z, z};
    repeat (2) @(negedge clk);
    chk("reset state", all_out(), 32'd0);
    rst = 1'b0;

    foreach (tbl[k]) cyc(tbl[k].name, tbl[k].i, tbl[k].e, tbl[k].comb);
    drain("drain1");

    // load-use on rs: one-cycle stall, bubble, then the consumer issues
    cyc("lu lw", mi(1, LW, 0, 1, 5, 0, 0),
        mk(3'b010, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("lu stall", mi(1, R, ADD, 5, 6, 7, 0), z, 4'b1000);
    cyc("lu go", mi(1, R, ADD, 5, 6, 7, 0),
        mk(3'b010, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0), 4'b0000);
    // load to r0 never stalls
    cyc("lw r0", mi(1, LW, 0, 1, 0, 0, 0),
        mk(3'b010, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("add r0", mi(1, R, ADD, 0, 0, 7, 0),
        mk(3'b010, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0), 4'b0000);
    // rt match stalls R-type but not ADDI
    cyc("lw rt6", mi(1, LW, 0, 1, 6, 0, 0),
        mk(3'b010, 1, 0, 0, 6, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("addi rt6", mi(1, ADDI, 0, 1, 6, 0, 0),
        mk(3'b010, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0), 4'b0000);
    cyc("lw rt6b", mi(1, LW, 0, 1, 6, 0, 0),
        mk(3'b010, 1, 0, 0, 6, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("sub rt6", mi(1, R, SUB, 1, 6, 8, 0), z, 4'b1000);
    cyc("sub go", mi(1, R, SUB, 1, 6, 8, 0),
        mk(3'b110, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0), 4'b0000);
    // taken branch overrides a pending hazard and masks jumps
    cyc("tk lw", mi(1, LW, 0, 1, 5, 0, 0),
        mk(3'b010, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("tk hz", mi(1, R, ADD, 5, 6, 7, 1), z, 4'b0100);
    cyc("tk next", mi(1, R, ADD, 5, 6, 7, 0),
        mk(3'b010, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0), 4'b0000);
    cyc("tk jal", mi(1, JAL, 0, 1, 2, 3, 1), z, 4'b0100);
    cyc("tk ill", mi(1, 6'h3f, 0, 1, 2, 3, 1), z, 4'b0100);
    // illegal is suppressed while stalled, reported once issued
    cyc("ill lw", mi(1, LW, 0, 1, 5, 0, 0),
        mk(3'b010, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("ill stall", mi(1, 6'h3f, 0, 5, 2, 3, 0), z, 4'b1000);
    cyc("ill go", mi(1, 6'h3f, 0, 5, 2, 3, 0),
        mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 4'b0000);
    // a stalled JR does not flush
    cyc("jr lw", mi(1, LW, 0, 1, 5, 0, 0),
        mk(3'b010, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("jr stall", mi(1, R, JR, 5, 0, 0, 0), z, 4'b1011);
    cyc("jr go", mi(1, R, JR, 5, 0, 0, 0), z, 4'b0111);
    drain("drain2");

    // asynchronous reset with a full pipe
    cyc("fill add", mi(1, R, ADD, 1, 2, 3, 0),
        mk(3'b010, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0), 4'b0000);
    cyc("fill lw", mi(1, LW, 0, 1, 9, 0, 0),
        mk(3'b010, 1, 0, 0, 9, 1, 0, 1, 1, 0, 0), 4'b0000);
    cyc("fill jal", mi(1, JAL, 0, 1, 2, 3, 0),
        mk(3'b000, 0, 0, 0, 31, 0, 0, 1, 0, 1, 0), 4'b0110);
    id_valid = 1'b0;
    #1;
    chk("full pipe", {31'd0, all_out() != 32'd0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset", all_out(), 32'd0);
    @(negedge clk);
    chk("reset held", all_out(), 32'd0);
    rst = 1'b0;
    q = '{z, z, z};
    cyc("post rst", mi(1, R, SLT, 1, 2, 4, 0),
        mk(3'b111, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0), 4'b0000);
    drain("drain3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
